// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: FSM states, trace entry layout, end marker.
package commit_trace_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // 102-bit entry: pc, instr, we, rd, wdata.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } trace_entry_t;

   localparam logic [31:0] END_MARKER = 32'h0;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-side signals of the commit trace buffer.
interface commit_trace_buffer_if;

   logic        commit_valid_i;
   logic [31:0] commit_pc_i;
   logic [31:0] commit_instr_i;
   logic        commit_we_i;
   logic [4:0]  commit_rd_i;
   logic [31:0] commit_wdata_i;
   logic        stall_o;

   logic        trace_valid_o;
   logic        trace_ready_i;
   logic [31:0] trace_pc_o;
   logic [31:0] trace_instr_o;
   logic [31:0] trace_wdata_o;
   logic [4:0]  trace_rd_o;
   logic        trace_we_o;

   logic [15:0] retire_cnt_o;
   logic [7:0]  drop_cnt_o;
   logic        done_o;

   modport master (
      output commit_valid_i, commit_pc_i, commit_instr_i, commit_we_i, commit_rd_i,
             commit_wdata_i, trace_ready_i,
      input  stall_o, trace_valid_o, trace_pc_o, trace_instr_o, trace_wdata_o, trace_rd_o,
             trace_we_o, retire_cnt_o, drop_cnt_o, done_o
   );

   modport slave (
      input  commit_valid_i, commit_pc_i, commit_instr_i, commit_we_i, commit_rd_i,
             commit_wdata_i, trace_ready_i,
      output stall_o, trace_valid_o, trace_pc_o, trace_instr_o, trace_wdata_o, trace_rd_o,
             trace_we_o, retire_cnt_o, drop_cnt_o, done_o
   );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: DEPTH-entry circular buffer of trace entries; contents are not reset,
// only the pointers and occupancy are.
module trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         push,
   input  trace_entry_t wdata,
   input  logic         pop,
   output trace_entry_t rdata,
   output logic         full,
   output logic         empty
);

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer top: run FSM, retire/drop counters and stall/drop policy.
// Optional COMMIT_TRACE_STALL_EN back-pressures the CPU instead of dropping commits.
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned MAX_RETIRE = 25
) (
   input logic                 clk_i,
   input logic                 rst_n,
   commit_trace_buffer_if.slave bus
);

   localparam logic [15:0] MaxRetire = 16'(MAX_RETIRE);

   state_e       state_q, state_d;
   logic [15:0]  retire_cnt_q;
   logic [7:0]   drop_cnt_q;
   logic         push, pop, drop, stall, take, is_end;
   logic         full, empty;
   trace_entry_t wentry, rentry;

   always_comb begin
      wentry.pc    = bus.commit_pc_i;
      wentry.instr = bus.commit_instr_i;
      // r0 is hardwired, so a write to it is recorded as no write.
      wentry.we    = bus.commit_we_i & (bus.commit_rd_i != 5'd0);
      wentry.rd    = bus.commit_rd_i;
      wentry.wdata = bus.commit_wdata_i;
   end

   trace_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i(clk_i),
      .rst_n(rst_n),
      .push (push),
      .wdata(wentry),
      .pop  (pop),
      .rdata(rentry),
      .full (full),
      .empty(empty)
   );

   assign pop    = ~empty & bus.trace_ready_i;
   assign is_end = (bus.commit_instr_i == END_MARKER);

`ifdef COMMIT_TRACE_STALL_EN
   assign stall = (state_q == StRun) & full & ~pop;
`else
   assign stall = 1'b0;
`endif

   assign take = bus.commit_valid_i & ~stall & ((state_q == StIdle) | (state_q == StRun));

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         StIdle, StRun: begin
            if (take) begin
               state_d = StRun;
               if (is_end) begin
                  state_d = StDrain;
               end else if (full & ~pop) begin
                  drop = 1'b1;
               end else begin
                  push = 1'b1;
                  if (retire_cnt_q + 16'd1 == MaxRetire) state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (empty) state_d = StDone;
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         retire_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (push) retire_cnt_q <= retire_cnt_q + 16'd1;
         if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   // Head fields are masked while empty so stale memory never leaks out.
   assign bus.trace_valid_o = ~empty;
   assign bus.trace_pc_o    = empty ? '0 : rentry.pc;
   assign bus.trace_instr_o = empty ? '0 : rentry.instr;
   assign bus.trace_wdata_o = empty ? '0 : rentry.wdata;
   assign bus.trace_rd_o    = empty ? '0 : rentry.rd;
   assign bus.trace_we_o    = empty ? 1'b0 : rentry.we;
   assign bus.stall_o       = stall;
   assign bus.retire_cnt_o  = retire_cnt_q;
   assign bus.drop_cnt_o    = drop_cnt_q;
   assign bus.done_o        = (state_q == StDone);

endmodule
